adc_ltc2308_responder: RTL and testbench
========================================

ADC_LTC2308_RESPONDER -- requirements
Module: adc_ltc2308_responder

Interface
REQ-001 SHALL have parameter CONV_CYCLES, default 80, clk cycles from CONVST rise to result ready (1.6 us at 50 MHz).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, flops per synchronizer on adc_convst/adc_sck/adc_sdi.
REQ-003 SHALL have ports:
- clk, in, 1, single clock for all logic.
- reset, in, 1, synchronous, active-high.
- adc_convst, in, 1, conversion start from the ADC host.
- adc_sck, in, 1, serial clock from the host, at most clk/8.
- adc_sdi, in, 1, config bits from the host.
- adc_sdo, out, 1, result bits to the host.
- sample_req, out, 1, one-cycle request for a sample.
- sample_ch, out, 3, channel {O/S,S1,S0} of the active config.
- sample_single, out, 1, S/D bit of the active config.
- sample_uni, out, 1, UNI bit of the active config.
- sample_data, in, 12, sample value.
- sample_valid, in, 1, qualifies sample_data.
- busy, out, 1, high in CONV.
- frame_done, out, 1, one-cycle pulse when a shift frame ends.

Function
REQ-004 SHALL synchronize adc_convst, adc_sck and adc_sdi through SYNC_STAGES flops, then detect edges with one further register; host-edge-to-action latency SHALL be SYNC_STAGES+1 clk.
REQ-005 SHALL implement states IDLE, CONV, SHIFT.
REQ-006 IDLE: on a synchronized adc_convst rising edge:
- cfg_active <= cfg_next.
- pulse sample_req with sample_ch/single/uni taken from the new cfg_active.
- load the conversion counter and enter CONV.
REQ-007 CONV: counter runs CONV_CYCLES cycles; busy=1; the first sample_valid captures sample_data into the result register; later sample_valid pulses in the same CONV are ignored.
REQ-008 At the end of CONV with no sample_valid seen, result SHALL be 12'h000; enter SHIFT, bit index 11, cfg shift count 0.
REQ-009 SHIFT: adc_sdo = result[bit index] while the index is 0..11; adc_sdo = 0 after 12 bits have been sent.
REQ-010 SHIFT: each synchronized adc_sck rising edge SHALL shift adc_sdi into a 6-bit register MSB-first and increment the shift count (saturating at 12).
REQ-011 SHIFT: each synchronized adc_sck falling edge SHALL decrement the bit index, stopping after bit 0.
REQ-012 SHIFT: a synchronized adc_convst rising edge ends the frame:
- pulse frame_done.
- cfg_next <= shift register if the shift count is at least 6, else cfg_next is unchanged.
- then apply the REQ-006 actions in the same cycle and enter CONV (back-to-back frames).
REQ-013 adc_convst rising edges during CONV SHALL be ignored; adc_sck and adc_sdi activity during CONV and IDLE SHALL be ignored.
REQ-014 sample_valid outside CONV SHALL be ignored.
REQ-015 Outputs sample_ch, sample_single and sample_uni SHALL hold cfg_active continuously.

Reset
REQ-016 reset SHALL force:
- state IDLE.
- adc_sdo=0, busy=0, sample_req=0, frame_done=0.
- result=12'h000, shift register=0, counters=0.
- cfg_next=cfg_active=6'b100010 (single-ended, ch0, unipolar, no sleep).
- all synchronizer flops cleared.
REQ-017 reset asserted mid-CONV or mid-SHIFT SHALL abort the operation with no frame_done; the first synchronized adc_convst rise after reset release SHALL start a new conversion.

Configuration
REQ-018 Macro ADC_RESP_PROTO_CHECK_EN defined SHALL add outputs proto_err (1 bit, sticky, cleared only by reset) and err_count (8 bits, saturating at 255).
REQ-019 With the macro defined, err_count SHALL increment once for each of these events:
- adc_convst rise during CONV.
- adc_sck edge during CONV.
- a frame ending with a shift count below 6.
- CONV ending without sample_valid.
proto_err SHALL set on the first such event.
REQ-020 Macro undefined: these ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-021 Reset; CONVST pulse; sample_valid with 12'hA5C at CONV cycle 10; 12 SCK cycles -> sample_ch=0 and sample_uni=1; adc_sdo bits read 1010_0101_1100; busy high exactly 80 cycles.
REQ-022 Frame 1 shifts SDI=6'b110110 -> next CONVST gives sample_req with sample_ch=3'b101, sample_single=1, sample_uni=1.
REQ-023 No sample_valid in CONV -> adc_sdo all zeros; with macro, err_count=1 and proto_err=1.
REQ-024 Frame with only 4 SCK cycles then CONVST -> cfg unchanged (sample_ch unchanged); frame_done pulses once; with macro, err_count increments.
REQ-025 CONVST re-pulsed at CONV cycle 40 -> ignored, busy still ends at cycle 80, one sample_req only.
REQ-026 reset asserted during SHIFT at bit 6 -> adc_sdo=0, no frame_done, cfg reverts to 6'b100010.

Source files
------------

// File: rtl/adc_ltc2308_responder.sv
// Behavioural stand-in for an LTC2308 ADC: it answers CONVST/SCK/SDI from a host and serves samples over SDO.
// Define ADC_RESP_PROTO_CHECK_EN to add the proto_err / err_count protocol monitor outputs.
module adc_ltc2308_responder #(
   parameter int CONV_CYCLES = 80,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        adc_convst,
   input  logic        adc_sck,
   input  logic        adc_sdi,
   output logic        adc_sdo,
   output logic        sample_req,
   output logic [2:0]  sample_ch,
   output logic        sample_single,
   output logic        sample_uni,
   input  logic [11:0] sample_data,
   input  logic        sample_valid,
   output logic        busy,
   output logic        frame_done
`ifdef ADC_RESP_PROTO_CHECK_EN
   ,
   output logic        proto_err,
   output logic [7:0]  err_count
`endif
);

   localparam int CW = $clog2(CONV_CYCLES + 1);
   localparam logic [5:0] CFG_DEFAULT = 6'b100010;

   typedef enum logic [1:0] {ST_IDLE, ST_CONV, ST_SHIFT} state_t;

   state_t                 r_state;
   logic [SYNC_STAGES-1:0] r_convst_sync, r_sck_sync, r_sdi_sync;
   logic                   r_convst_d, r_sck_d;
   logic [CW-1:0]          r_cnt;
   logic                   r_got;
   logic [11:0]            r_result;
   logic [3:0]             r_bit_idx;
   logic                   r_sent;
   logic [5:0]             r_shift;
   logic [3:0]             r_shift_cnt;
   logic [5:0]             r_cfg_next, r_cfg_active;
   logic                   r_sdo, r_req, r_busy, r_frame_done;

   logic       w_convst_s, w_sck_s, w_sdi_s;
   logic       w_convst_rise, w_sck_rise, w_sck_fall;
   logic       w_capture, w_start;
   logic [11:0] w_result_final;
   logic [5:0] w_cfg_start;

   assign w_convst_s    = r_convst_sync[SYNC_STAGES-1];
   assign w_sck_s       = r_sck_sync[SYNC_STAGES-1];
   assign w_sdi_s       = r_sdi_sync[SYNC_STAGES-1];
   assign w_convst_rise = w_convst_s & ~r_convst_d;
   assign w_sck_rise    = w_sck_s & ~r_sck_d;
   assign w_sck_fall    = ~w_sck_s & r_sck_d;

   assign w_capture      = (r_state == ST_CONV) && sample_valid && !r_got;
   assign w_result_final = w_capture ? sample_data : r_result;
   assign w_start        = w_convst_rise && (r_state != ST_CONV);
   // A frame only commits a new config once the whole 6-bit word was clocked in.
   assign w_cfg_start    = (r_state == ST_SHIFT && r_shift_cnt >= 4'd6) ? r_shift : r_cfg_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_convst_sync <= '0;
         r_sck_sync    <= '0;
         r_sdi_sync    <= '0;
         r_convst_d    <= 1'b0;
         r_sck_d       <= 1'b0;
      end else begin
         r_convst_sync <= (r_convst_sync << 1) | SYNC_STAGES'(adc_convst);
         r_sck_sync    <= (r_sck_sync << 1) | SYNC_STAGES'(adc_sck);
         r_sdi_sync    <= (r_sdi_sync << 1) | SYNC_STAGES'(adc_sdi);
         r_convst_d    <= w_convst_s;
         r_sck_d       <= w_sck_s;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_got        <= 1'b0;
         r_result     <= '0;
         r_bit_idx    <= '0;
         r_sent       <= 1'b0;
         r_shift      <= '0;
         r_shift_cnt  <= '0;
         r_cfg_next   <= CFG_DEFAULT;
         r_cfg_active <= CFG_DEFAULT;
         r_sdo        <= 1'b0;
         r_req        <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_req        <= 1'b0;
         r_frame_done <= 1'b0;
         case (r_state)
            ST_CONV: begin
               if (w_capture) begin
                  r_result <= sample_data;
                  r_got    <= 1'b1;
               end
               if (r_cnt == '0) begin
                  r_state     <= ST_SHIFT;
                  r_busy      <= 1'b0;
                  r_result    <= w_result_final;
                  r_sdo       <= w_result_final[11];
                  r_bit_idx   <= 4'd11;
                  r_sent      <= 1'b0;
                  r_shift     <= '0;
                  r_shift_cnt <= '0;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            ST_SHIFT: begin
               r_frame_done <= w_convst_rise;
               if (w_sck_rise) begin
                  if (r_shift_cnt < 4'd6)
                     r_shift <= {r_shift[4:0], w_sdi_s};
                  if (r_shift_cnt < 4'd12)
                     r_shift_cnt <= r_shift_cnt + 4'd1;
               end
               if (w_sck_fall && !r_sent) begin
                  if (r_bit_idx == 4'd0) begin
                     r_sent <= 1'b1;
                     r_sdo  <= 1'b0;
                  end else begin
                     r_bit_idx <= r_bit_idx - 4'd1;
                     r_sdo     <= r_result[r_bit_idx - 4'd1];
                  end
               end
            end
            default: ;
         endcase
         // Starting a conversion overrides any same-cycle SHIFT bookkeeping above.
         if (w_start) begin
            r_state      <= ST_CONV;
            r_busy       <= 1'b1;
            r_req        <= 1'b1;
            r_cfg_next   <= w_cfg_start;
            r_cfg_active <= w_cfg_start;
            r_cnt        <= CW'(CONV_CYCLES - 1);
            r_got        <= 1'b0;
            r_result     <= '0;
            r_sdo        <= 1'b0;
         end
      end
   end

   assign adc_sdo       = r_sdo;
   assign sample_req    = r_req;
   assign busy          = r_busy;
   assign frame_done    = r_frame_done;
   assign sample_single = r_cfg_active[5];
   assign sample_ch     = r_cfg_active[4:2];
   assign sample_uni    = r_cfg_active[1];

`ifdef ADC_RESP_PROTO_CHECK_EN
   logic       w_ev_convst, w_ev_sck, w_ev_short, w_ev_noval;
   logic [8:0] w_err_sum;

   assign w_ev_convst = (r_state == ST_CONV) && w_convst_rise;
   assign w_ev_sck    = (r_state == ST_CONV) && (w_sck_rise || w_sck_fall);
   assign w_ev_short  = (r_state == ST_SHIFT) && w_convst_rise && (r_shift_cnt < 4'd6);
   assign w_ev_noval  = (r_state == ST_CONV) && (r_cnt == '0) && !r_got && !sample_valid;
   assign w_err_sum   = {1'b0, err_count} + 9'(w_ev_convst) + 9'(w_ev_sck)
                        + 9'(w_ev_short) + 9'(w_ev_noval);

   always_ff @(posedge clk) begin
      if (reset) begin
         proto_err <= 1'b0;
         err_count <= '0;
      end else begin
         proto_err <= proto_err | w_ev_convst | w_ev_sck | w_ev_short | w_ev_noval;
         err_count <= (w_err_sum > 9'd255) ? 8'd255 : w_err_sum[7:0];
      end
   end
`endif

endmodule

// File: tb/tb_adc_ltc2308_responder.sv
// Randomized self-checking bench for adc_ltc2308_responder against a frame-level host model.
module tb_adc_ltc2308_responder;
   localparam int CONV = 80;
   localparam int SS   = 2;

   logic        clk = 1'b0, reset = 1'b1;
   logic        adc_convst = 1'b0, adc_sck = 1'b0, adc_sdi = 1'b0;
   logic        sample_valid = 1'b0;
   logic [11:0] sample_data = '0;
   logic        adc_sdo, sample_req, sample_single, sample_uni, busy, frame_done;
   logic [2:0]  sample_ch;
`ifdef ADC_RESP_PROTO_CHECK_EN
   logic        proto_err;
   logic [7:0]  err_count;
`endif

   adc_ltc2308_responder #(.CONV_CYCLES(CONV), .SYNC_STAGES(SS)) dut (
      .clk(clk), .reset(reset), .adc_convst(adc_convst), .adc_sck(adc_sck),
      .adc_sdi(adc_sdi), .adc_sdo(adc_sdo), .sample_req(sample_req),
      .sample_ch(sample_ch), .sample_single(sample_single), .sample_uni(sample_uni),
      .sample_data(sample_data), .sample_valid(sample_valid), .busy(busy),
      .frame_done(frame_done)
`ifdef ADC_RESP_PROTO_CHECK_EN
      , .proto_err(proto_err), .err_count(err_count)
`endif
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0;
   int req_total = 0, fd_total = 0, busy_total = 0;

   // Host-side view of the config word: {S/D, O/S, S1, S0, UNI, SLP}.
   logic [5:0] m_next = 6'b100010, m_active = 6'b100010, m_shifted = '0;
   bit         m_in_shift = 0;
   int         m_nsck = 0, m_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (sample_req) req_total++;
      if (frame_done) fd_total++;
      if (busy) busy_total++;
   end

   task automatic run_frame(input logic [11:0] data, input int valid_at, input int nsck,
                            input logic [5:0] cfg, input bit repulse);
      int r0, f0, b0, lat;
      bit exp_fd;
      logic [15:0] rx, ex;
      logic [11:0] res;
      exp_fd = m_in_shift;
      if (m_in_shift) begin
         if (m_nsck >= 6) m_next = m_shifted;
         else m_err++;
      end
      m_active = m_next;
      if (repulse) m_err++;
      if (valid_at < 0) m_err++;

      @(negedge clk);
      #1;
      r0 = req_total; f0 = fd_total; b0 = busy_total;
      adc_convst = 1'b1;
      lat = 0;
      while (!sample_req && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("convst_latency", lat, SS + 1);
      check("req_cfg", {sample_single, sample_ch, sample_uni},
            {m_active[5], m_active[4:2], m_active[1]});

      for (int n = 1; n < CONV + 20; n++) begin
         @(negedge clk);
         if (!busy) break;
         adc_convst   = (n < 3) || (repulse && n >= 40 && n < 43);
         sample_valid = (valid_at >= 0) && (n == valid_at || n == valid_at + 5);
         sample_data  = (n == valid_at) ? data : ~data;
      end
      sample_valid = 1'b0;
      adc_convst   = 1'b0;
      #1;
      check("busy_cycles", busy_total - b0, CONV);
      check("req_count", req_total - r0, 1);
      check("frame_done_count", fd_total - f0, {31'b0, exp_fd});

      // Late sample_valid while shifting must not disturb the result.
      @(negedge clk);
      sample_data  = ~data;
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;

      rx = '0;
      for (int i = 0; i < nsck; i++) begin
         adc_sdi = (i < 6) ? cfg[5-i] : 1'($urandom);
         repeat (4) @(negedge clk);
         rx[15-i] = adc_sdo;
         adc_sck = 1'b1;
         repeat (4) @(negedge clk);
         adc_sck = 1'b0;
      end
      res = (valid_at >= 0) ? data : 12'h000;
      ex  = {res, 4'b0000};
      for (int i = nsck; i < 16; i++) ex[15-i] = 1'b0;
      check("sdo_bits", rx, ex);
      $display("frame data=%03h valid_at=%0d nsck=%0d cfg=%06b repulse=%0d sdo=%04h",
               data, valid_at, nsck, cfg, repulse, rx);
      m_in_shift = 1;
      m_shifted  = cfg;
      m_nsck     = nsck;
   endtask

   task automatic check_proto;
`ifdef ADC_RESP_PROTO_CHECK_EN
      @(negedge clk);
      check("err_count", err_count, (m_err > 255) ? 255 : m_err);
      check("proto_err", proto_err, m_err != 0);
`endif
   endtask

   initial begin
      int va, ns;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_sdo", adc_sdo, 0);
      check("rst_busy", busy, 0);
      check("rst_req", sample_req, 0);
      check("rst_fd", frame_done, 0);
      check("rst_cfg", {sample_single, sample_ch, sample_uni}, 5'b10001);

      run_frame(12'hA5C, 10, 12, 6'b110110, 0);
      run_frame(12'($urandom), 30, 12, 6'($urandom), 0);
      run_frame(12'($urandom), -1, 12, 6'($urandom), 0);
      check_proto();
      run_frame(12'($urandom), 20, 4, 6'($urandom), 1);
      run_frame(12'($urandom), 15, 14, 6'($urandom), 0);

      for (int k = 0; k < 6; k++) begin
         va = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(1, 70));
         ns = int'($urandom_range(3, 14));
         run_frame(12'($urandom), va, ns, 6'($urandom), 1'($urandom_range(0, 1)));
      end
      check_proto();

      // Abort mid-SHIFT: everything reverts, and the next frame sees no frame_done.
      run_frame(12'($urandom), 25, 6, 6'b011011, 0);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("abort_sdo", adc_sdo, 0);
      check("abort_busy", busy, 0);
      check("abort_cfg", {sample_single, sample_ch, sample_uni}, 5'b10001);
      m_next = 6'b100010;
      m_in_shift = 0;
      m_err = 0;
      run_frame(12'($urandom), 40, 12, 6'($urandom), 0);
      check_proto();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end
endmodule
